// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program-counter register and fetch-request sequencer (BOOT -> FETCH <-> STALL).
// Latency: pc updates on the edge after an accepted fetch; fetch_valid is combinational in the same cycle.
// Backpressure: imem_ready=0 or stall=1 holds pc; redirects seen while held are parked in a pending register.
// Optional build macro PC_EXCEPTION_EN adds exc_req/epc and the EXC_VECTOR redirect.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h00000000
`ifdef PC_EXCEPTION_EN
  , parameter logic [31:0] EXC_VECTOR = 32'h80000180
`endif
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc_increment,
  input  logic [31:0] branch_target,
  input  logic        branch_taken,
  input  logic [31:0] jump_target,
  input  logic        jump,
  input  logic        stall,
  input  logic        imem_ready,
`ifdef PC_EXCEPTION_EN
  input  logic        exc_req,
  output logic [31:0] epc,
`endif
  output logic [31:0] pc,
  output logic        imem_req,
  output logic        fetch_valid
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    STALL = 2'd2
  } state_t;

  localparam logic [31:0] ALIGN_MASK = 32'hFFFFFFFC;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        imem_req_q, imem_req_d;
  logic        pend_vld_q, pend_vld_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
`ifdef PC_EXCEPTION_EN
  logic [31:0] epc_q, epc_d;
`endif

  // Word-aligned versions of every source pc can be loaded from.
  logic [31:0] jump_al;
  logic [31:0] branch_al;
  logic [31:0] inc_al;
  logic [31:0] redirect_tgt;
  logic [31:0] next_pc;
  logic        redirect;
  logic        advance;

  assign jump_al      = jump_target & ALIGN_MASK;
  assign branch_al    = branch_target & ALIGN_MASK;
  assign inc_al       = pc_increment & ALIGN_MASK;
  assign redirect     = jump | branch_taken;
  // Jump beats branch when both arrive together.
  assign redirect_tgt = jump ? jump_al : branch_al;

  assign fetch_valid  = imem_req_q & imem_ready & ~stall;
  assign advance      = fetch_valid;

  // Next fetch address: fresh redirect, then parked redirect, then sequential pc+4.
  always_comb begin
    next_pc = inc_al;
    if (jump) begin
      next_pc = jump_al;
    end else if (branch_taken) begin
      next_pc = branch_al;
    end else if (pend_vld_q) begin
      next_pc = pend_tgt_q;
    end
  end

  // Next-state computation for the FSM, pc, pending redirect and epc.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    imem_req_d = imem_req_q;
    pend_vld_d = pend_vld_q;
    pend_tgt_d = pend_tgt_q;
`ifdef PC_EXCEPTION_EN
    epc_d      = epc_q;
`endif

    case (state_q)
      BOOT: begin
        state_d    = FETCH;
        imem_req_d = 1'b1;
      end
      FETCH: begin
        if (stall) begin
          state_d    = STALL;
          imem_req_d = 1'b0;
        end
      end
      STALL: begin
        if (!stall) begin
          state_d    = FETCH;
          imem_req_d = 1'b1;
        end
      end
      default: begin
        state_d    = BOOT;
        imem_req_d = 1'b0;
      end
    endcase

    // An accepted fetch loads pc and consumes any parked redirect;
    // otherwise a redirect is parked (a newer one replaces an older one).
    if (advance) begin
      pc_d       = next_pc;
      pend_vld_d = 1'b0;
    end else if (redirect) begin
      pend_vld_d = 1'b1;
      pend_tgt_d = redirect_tgt;
    end

`ifdef PC_EXCEPTION_EN
    // Exceptions pre-empt everything except BOOT and ignore stall/ready.
    if (exc_req && (state_q != BOOT)) begin
      pc_d       = EXC_VECTOR & ALIGN_MASK;
      epc_d      = pc_q;
      state_d    = FETCH;
      imem_req_d = 1'b1;
      pend_vld_d = 1'b0;
    end
`endif
  end

  // State, pc and registered outputs; synchronous reset wins over all inputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC & ALIGN_MASK;
      imem_req_q <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_tgt_q <= 32'h0;
`ifdef PC_EXCEPTION_EN
      epc_q      <= 32'h0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      imem_req_q <= imem_req_d;
      pend_vld_q <= pend_vld_d;
      pend_tgt_q <= pend_tgt_d;
`ifdef PC_EXCEPTION_EN
      epc_q      <= epc_d;
`endif
    end
  end

  assign pc       = pc_q;
  assign imem_req = imem_req_q;
`ifdef PC_EXCEPTION_EN
  assign epc      = epc_q;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: vector table plus hand sequences for stall/redirect/exception.
module tb_pc_fetch_ctrl;

  logic        clock;
  logic        reset;
  logic [31:0] pc_increment;
  logic [31:0] branch_target;
  logic        branch_taken;
  logic [31:0] jump_target;
  logic        jump;
  logic        stall;
  logic        imem_ready;
  logic [31:0] pc;
  logic        imem_req;
  logic        fetch_valid;
`ifdef PC_EXCEPTION_EN
  logic        exc_req;
  logic [31:0] epc;
`endif

  int errors = 0;
  int checks = 0;

  pc_fetch_ctrl dut (
    .clock         (clock),
    .reset         (reset),
    .pc_increment  (pc_increment),
    .branch_target (branch_target),
    .branch_taken  (branch_taken),
    .jump_target   (jump_target),
    .jump          (jump),
    .stall         (stall),
    .imem_ready    (imem_ready),
`ifdef PC_EXCEPTION_EN
    .exc_req       (exc_req),
    .epc           (epc),
`endif
    .pc            (pc),
    .imem_req      (imem_req),
    .fetch_valid   (fetch_valid)
  );

  // External pc+4 adder.
  assign pc_increment = pc + 32'd4;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        r;
    logic        rdy;
    logic        st;
    logic        j;
    logic [31:0] jt;
    logic        b;
    logic [31:0] bt;
    logic [31:0] e_pc;
    logic        e_req;
    logic        e_fv;
  } vec_t;

  localparam int NV = 29;
  vec_t vecs [NV];

  function automatic vec_t mk(logic r, logic rdy, logic st, logic j, logic [31:0] jt,
                              logic b, logic [31:0] bt,
                              logic [31:0] e_pc, logic e_req, logic e_fv);
    vec_t v;
    v.r = r; v.rdy = rdy; v.st = st; v.j = j; v.jt = jt; v.b = b; v.bt = bt;
    v.e_pc = e_pc; v.e_req = e_req; v.e_fv = e_fv;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge; outputs settle 1 time unit later.
  task automatic drive(input logic r, input logic rdy, input logic st, input logic j,
                       input logic [31:0] jt, input logic b, input logic [31:0] bt);
    @(negedge clock);
    reset         = r;
    imem_ready    = rdy;
    stall         = st;
    jump          = j;
    jump_target   = jt;
    branch_taken  = b;
    branch_target = bt;
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] e_pc, input logic e_req, input logic e_fv);
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".imem_req"}, {31'h0, imem_req}, {31'h0, e_req});
    chk({tag, ".fetch_valid"}, {31'h0, fetch_valid}, {31'h0, e_fv});
  endtask

  initial begin
    reset = 1'b1; imem_ready = 1'b0; stall = 1'b0;
    jump = 1'b0; jump_target = 32'h0; branch_taken = 1'b0; branch_target = 32'h0;
`ifdef PC_EXCEPTION_EN
    exc_req = 1'b0;
`endif

    //             r  rdy st j  jt            b  bt        e_pc          req fv
    vecs[0]  = mk(1, 1, 0, 0, 32'h0,        0, 32'h0,   32'h00000000, 0, 0); // reset
    vecs[1]  = mk(0, 1, 0, 0, 32'h0,        0, 32'h0,   32'h00000000, 0, 0); // BOOT
    vecs[2]  = mk(0, 1, 0, 0, 32'h0,        0, 32'h0,   32'h00000000, 1, 1);
    vecs[3]  = mk(0, 1, 0, 0, 32'h0,        0, 32'h0,   32'h00000004, 1, 1);
    vecs[4]  = mk(0, 0, 0, 0, 32'h0,        0, 32'h0,   32'h00000008, 1, 0); // not ready x3
    vecs[5]  = mk(0, 0, 0, 0, 32'h0,        0, 32'h0,   32'h00000008, 1, 0);
    vecs[6]  = mk(0, 0, 0, 0, 32'h0,        0, 32'h0,   32'h00000008, 1, 0);
    vecs[7]  = mk(0, 1, 0, 0, 32'h0,        0, 32'h0,   32'h00000008, 1, 1);
    vecs[8]  = mk(0, 0, 0, 0, 32'h0,        1, 32'h40,  32'h0000000C, 1, 0); // branch parked
    vecs[9]  = mk(0, 1, 0, 0, 32'h0,        0, 32'h0,   32'h0000000C, 1, 1);
    vecs[10] = mk(0, 1, 0, 0, 32'h0,        0, 32'h0,   32'h00000040, 1, 1); // pending used
    vecs[11] = mk(0, 1, 0, 1, 32'h100,      1, 32'h40,  32'h00000044, 1, 1); // jump beats branch
    vecs[12] = mk(0, 1, 0, 1, 32'h12,       0, 32'h0,   32'h00000100, 1, 1); // misaligned target
    vecs[13] = mk(0, 1, 1, 0, 32'h0,        0, 32'h0,   32'h00000010, 1, 0); // stall
    vecs[14] = mk(0, 1, 1, 0, 32'h0,        0, 32'h0,   32'h00000010, 0, 0);
    vecs[15] = mk(0, 1, 0, 0, 32'h0,        0, 32'h0,   32'h00000010, 0, 0);
    vecs[16] = mk(0, 1, 0, 0, 32'h0,        0, 32'h0,   32'h00000010, 1, 1); // refetch
    vecs[17] = mk(0, 1, 0, 0, 32'h0,        0, 32'h0,   32'h00000014, 1, 1);
    vecs[18] = mk(0, 0, 0, 0, 32'h0,        1, 32'h200, 32'h00000018, 1, 0); // park branch
    vecs[19] = mk(0, 0, 0, 1, 32'h300,      0, 32'h0,   32'h00000018, 1, 0); // overwrite
    vecs[20] = mk(0, 1, 0, 0, 32'h0,        0, 32'h0,   32'h00000018, 1, 1);
    vecs[21] = mk(0, 1, 0, 0, 32'h0,        0, 32'h0,   32'h00000300, 1, 1);
    vecs[22] = mk(0, 1, 0, 1, 32'hFFFFFFFC, 0, 32'h0,   32'h00000304, 1, 1);
    vecs[23] = mk(0, 1, 0, 0, 32'h0,        0, 32'h0,   32'hFFFFFFFC, 1, 1); // wrap
    vecs[24] = mk(0, 1, 0, 0, 32'h0,        0, 32'h0,   32'h00000000, 1, 1);
    vecs[25] = mk(1, 0, 0, 0, 32'h0,        1, 32'h500, 32'h00000004, 1, 0); // reset mid-fetch
    vecs[26] = mk(0, 1, 0, 0, 32'h0,        0, 32'h0,   32'h00000000, 0, 0);
    vecs[27] = mk(0, 1, 0, 0, 32'h0,        0, 32'h0,   32'h00000000, 1, 1);
    vecs[28] = mk(0, 1, 0, 0, 32'h0,        0, 32'h0,   32'h00000004, 1, 1); // redirect dropped

    @(negedge clock);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].r, vecs[i].rdy, vecs[i].st, vecs[i].j, vecs[i].jt, vecs[i].b, vecs[i].bt);
      chk_out($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_req, vecs[i].e_fv);
    end

    // Redirect arriving in the stalling cycle survives the stall and loads after the refetch.
    drive(0, 1, 1, 1, 32'h600, 0, 32'h0);
    chk_out("stall_redir_a", 32'h8, 1'b1, 1'b0);
    drive(0, 1, 0, 0, 32'h0, 0, 32'h0);
    chk_out("stall_redir_b", 32'h8, 1'b0, 1'b0);
    drive(0, 1, 0, 0, 32'h0, 0, 32'h0);
    chk_out("stall_redir_c", 32'h8, 1'b1, 1'b1);
    drive(0, 1, 0, 0, 32'h0, 0, 32'h0);
    chk_out("stall_redir_d", 32'h600, 1'b1, 1'b1);
    drive(0, 1, 0, 0, 32'h0, 0, 32'h0);
    chk_out("stall_redir_e", 32'h604, 1'b1, 1'b1);

`ifdef PC_EXCEPTION_EN
    // Exception taken from STALL at pc=0x20.
    drive(0, 1, 0, 1, 32'h20, 0, 32'h0);
    chk_out("exc_a", 32'h608, 1'b1, 1'b1);
    drive(0, 1, 1, 0, 32'h0, 0, 32'h0);
    chk_out("exc_b", 32'h20, 1'b1, 1'b0);
    chk("exc_epc_reset", epc, 32'h0);
    drive(0, 1, 1, 0, 32'h0, 0, 32'h0);
    exc_req = 1'b1;
    #1;
    chk_out("exc_c", 32'h20, 1'b0, 1'b0);
    drive(0, 1, 1, 0, 32'h0, 0, 32'h0);
    exc_req = 1'b0;
    #1;
    chk_out("exc_d", 32'h80000180, 1'b1, 1'b0);
    chk("exc_epc", epc, 32'h20);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, is the PC value loaded on reset.
REQ-002 Parameter EXC_VECTOR, default 32'h80000180, is the exception redirect target; it is used only with PC_EXCEPTION_EN.
REQ-003 Port clock  in  1  is the single rising-edge clock.
REQ-004 Port reset  in  1  is the reset; it SHALL be synchronous and active-high.
REQ-005 Port pc_increment  in  32  is pc+4 from the external PC adder.
REQ-006 Port branch_target  in  32  is the target from the external branch address adder.
REQ-007 Port branch_taken  in  1  requests a redirect to branch_target.
REQ-008 Port jump_target  in  32  is the jump destination.
REQ-009 Port jump  in  1  requests a redirect to jump_target.
REQ-010 Port stall  in  1  is the pipeline hold request.
REQ-011 Port imem_ready  in  1  means instruction memory accepts the current request.
REQ-012 Port pc  out  32  is the current fetch address, which also drives the pc+4 adder input.
REQ-013 Port imem_req  out  1  means a fetch request is outstanding at address pc.
REQ-014 Port fetch_valid  out  1  pulses when the fetch at pc is accepted this cycle.
REQ-015 Ports exc_req  in  1  and epc  out  32  SHALL exist only with PC_EXCEPTION_EN.

Function
REQ-016 The block SHALL have exactly three states: BOOT, FETCH and STALL.
REQ-017 BOOT SHALL drive imem_req=0 and SHALL move to FETCH after exactly one cycle.
REQ-018 FETCH SHALL drive imem_req=1; fetch_valid SHALL be combinational: imem_req & imem_ready & !stall.
REQ-019 In FETCH with imem_ready=1 and stall=0, pc SHALL load next_pc on that edge, giving back-to-back fetches at one per cycle.
REQ-020 In FETCH with imem_ready=0, pc SHALL hold and the state SHALL remain FETCH.
REQ-021 In FETCH with stall=1, the state SHALL move to STALL and pc SHALL hold.
REQ-022 STALL SHALL drive imem_req=0; when stall=0 the state SHALL return to FETCH and refetch the same pc.
REQ-023 next_pc priority SHALL be: exception, then jump_target, then branch_target, then the pending redirect, then pc_increment.
REQ-024 A redirect (jump or branch_taken) that arrives when pc cannot advance SHALL be latched into a pending register; the pending flag SHALL set.
REQ-025 A later redirect SHALL overwrite the pending target.
REQ-026 The pending redirect SHALL be consumed, and the flag cleared, on the next pc load.
REQ-027 When jump and branch_taken are asserted together, jump SHALL win.
REQ-028 All targets SHALL be loaded with bits [1:0] forced to 0, so pc[1:0] is always 0.
REQ-029 Wrap-around SHALL be taken directly from pc_increment (for example, 32'hFFFFFFFC advances to 32'h00000000), with no extra logic.

Reset
REQ-030 On reset, the next edge SHALL set pc=RESET_PC, the state to BOOT, imem_req=0, fetch_valid=0, pending flag=0 and epc=0.
REQ-031 Reset during an outstanding fetch SHALL drop imem_req on the next cycle and discard any pending redirect.
REQ-032 Reset SHALL override every other input.

Configuration
REQ-033 Macro PC_EXCEPTION_EN defined: exc_req=1 SHALL load pc=EXC_VECTOR and epc=pc on the next edge in any non-BOOT state, ignoring stall and imem_ready, force the state to FETCH, and clear the pending redirect.
REQ-034 Macro PC_EXCEPTION_EN undefined: exc_req, epc and the EXC_VECTOR logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-035 Reset release with imem_ready held at 1 -> one BOOT cycle (imem_req=0), then pc 0,4,8,C on consecutive cycles with fetch_valid=1 each cycle.
REQ-036 imem_ready=0 for 3 cycles at pc=8 -> pc stays 8, imem_req=1, fetch_valid=0; when ready returns, pc=C on the next edge.
REQ-037 branch_taken=1 with branch_target=32'h40 while imem_ready=0 -> pending set; when ready returns, pc=32'h40 and pending clear.
REQ-038 jump=1 (jump_target=32'h100) and branch_taken=1 (branch_target=32'h40) in the same accepted cycle -> pc=32'h100.
REQ-039 stall=1 for 2 cycles at pc=10 -> STALL with imem_req=0; on release, refetch at 10, then 14.
REQ-040 With PC_EXCEPTION_EN, exc_req=1 at pc=20 during stall -> pc=32'h80000180, epc=20, next state FETCH.
